// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: PC index/tag extraction and
// direction-counter constants.
package bp_pkg;

  localparam int PC_MAX_W = 64;

  typedef logic [PC_MAX_W-1:0] pc_max_t;

  function automatic pc_max_t bp_index(input pc_max_t pc, input int idx_w);
    pc_max_t mask_v;
    mask_v = (64'd1 << idx_w) - 64'd1;
    return (pc >> 2) & mask_v;
  endfunction

  function automatic pc_max_t bp_tag(input pc_max_t pc, input int idx_w);
    return pc >> (idx_w + 32'sd2);
  endfunction

  // Weakly-taken is the lowest counter value whose MSB is set.
  function automatic int weak_taken(input int ctr_bits);
    return 32'sd1 << (ctr_bits - 32'sd1);
  endfunction

  function automatic int ctr_max(input int ctr_bits);
    return (32'sd1 << ctr_bits) - 32'sd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down step; inc and dec together hold the value.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  // Next value clamped at all-ones on increment and at zero on decrement
  always_comb begin
    nxt = cur;
    if (inc && !dec) begin
      if (cur != {W{1'b1}}) nxt = cur + W'(1'b1);
      else                  nxt = cur;
    end else if (dec && !inc) begin
      if (cur != {W{1'b0}}) nxt = cur - W'(1'b1);
      else                  nxt = cur;
    end else begin
      nxt = cur;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: zero-latency lookup
// from IF, training from resolved branches in MEM, plus branch/mispredict totals.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } bp_entry_t;

  bp_entry_t        tbl_r [ENTRIES];
  logic [CNT_W-1:0] br_count_r;
  logic [CNT_W-1:0] mispred_count_r;

  logic [IDX_W-1:0]    lk_idx_s;
  logic [TAG_W-1:0]    lk_tag_s;
  bp_entry_t           lk_ent_s;
  logic                lk_hit_s;
  logic [IDX_W-1:0]    up_idx_s;
  logic [TAG_W-1:0]    up_tag_s;
  bp_entry_t           up_ent_s;
  logic                up_hit_s;
  logic [CTR_BITS-1:0] up_ctr_nxt_s;
  logic [CNT_W-1:0]    br_nxt_s;
  logic [CNT_W-1:0]    mispred_nxt_s;

  assign lk_idx_s = IDX_W'(bp_index(PC_MAX_W'(lookup_pc), IDX_W));
  assign lk_tag_s = TAG_W'(bp_tag(PC_MAX_W'(lookup_pc), IDX_W));
  assign up_idx_s = IDX_W'(bp_index(PC_MAX_W'(upd_pc), IDX_W));
  assign up_tag_s = TAG_W'(bp_tag(PC_MAX_W'(upd_pc), IDX_W));
  assign lk_ent_s = tbl_r[lk_idx_s];
  assign up_ent_s = tbl_r[up_idx_s];
  assign up_hit_s = up_ent_s.valid && (up_ent_s.tag == up_tag_s);

  // Prediction reads current table state, so a same-cycle update is seen next cycle
  always_comb begin
    lk_hit_s   = lk_ent_s.valid && (lk_ent_s.tag == lk_tag_s);
    pred_taken = lk_hit_s && lk_ent_s.ctr[CTR_BITS-1];
    if (pred_taken) pred_target = lk_ent_s.target;
    else            pred_target = '0;
  end

  sat_counter #(.W(CTR_BITS)) u_dir_ctr (
    .cur (up_ent_s.ctr),
    .inc (upd_taken),
    .dec (!upd_taken),
    .nxt (up_ctr_nxt_s)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .cur (br_count_r),
    .inc (upd_valid),
    .dec (1'b0),
    .nxt (br_nxt_s)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .cur (mispred_count_r),
    .inc (upd_valid && upd_mispred),
    .dec (1'b0),
    .nxt (mispred_nxt_s)
  );

  // Table training and performance counters; reset wins over a concurrent update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_r[i].valid  <= 1'b0;
        tbl_r[i].tag    <= '0;
        tbl_r[i].target <= '0;
        tbl_r[i].ctr    <= CTR_INIT;
      end
      br_count_r      <= '0;
      mispred_count_r <= '0;
    end else begin
      if (upd_valid) begin
        if (up_hit_s) begin
          tbl_r[up_idx_s].ctr <= up_ctr_nxt_s;
          if (upd_taken) tbl_r[up_idx_s].target <= upd_target;
        end else if (upd_taken) begin
          // Not-taken misses never allocate, keeping cold branches out of the table
          tbl_r[up_idx_s].valid  <= 1'b1;
          tbl_r[up_idx_s].tag    <= up_tag_s;
          tbl_r[up_idx_s].target <= upd_target;
          tbl_r[up_idx_s].ctr    <= CTR_WEAK;
        end
      end
      br_count_r      <= br_nxt_s;
      mispred_count_r <= mispred_nxt_s;
    end
  end

  assign br_count      = br_count_r;
  assign mispred_count = mispred_count_r;

endmodule
